// File: rtl/constant_memory_loader_if.sv
// Host-side bus of the constant memory loader: a burst command channel
// (base address + word count), a 32-bit data channel and an abort strobe.
//
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both 1. The source holds valid and its payload
// stable until that edge. Ready may be asserted with or without valid.
//
// Signals:
//   cmd_valid / cmd_ready   command channel handshake
//   cmd_base_addr           first write address of the burst
//   cmd_count               words in the burst, 0..DEPTH
//   data_valid / data_ready data channel handshake
//   data                    constant word
//   abort                   cancel the burst in progress
interface constant_memory_loader_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_base_addr;
  logic [ADDR_WIDTH:0]   cmd_count;
  logic                  data_valid;
  logic                  data_ready;
  logic [31:0]           data;
  logic                  abort;

  modport master (
    output cmd_valid, cmd_base_addr, cmd_count, data_valid, data, abort,
    input  cmd_ready, data_ready
  );

  modport slave (
    input  cmd_valid, cmd_base_addr, cmd_count, data_valid, data, abort,
    output cmd_ready, data_ready
  );
endinterface

// File: rtl/constant_memory_loader.sv
// Write-side driver for the CGRA constant memory. Takes a burst command and a
// stream of 32-bit words from the host and turns each accepted word into a
// registered single-word write (address, line, enable) one cycle later.
// Addresses advance modulo DEPTH = 1 << ADDR_WIDTH.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   host                command/data/abort channels (slave side)
//   memory_write_addr   write address to the constant memory
//   memory_line         write data to the constant memory
//   write_memory_en     write enable to the constant memory
//   busy                a burst is in progress (state != IDLE)
//   done                one-cycle pulse when a burst completes
//   wrap                sticky: the current burst wrapped DEPTH-1 -> 0
//   state_dbg           current FSM state (IDLE=0, LOAD=1, DONE=2)
module constant_memory_loader #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  constant_memory_loader_if.slave host,
  output logic [ADDR_WIDTH-1:0] memory_write_addr,
  output logic [31:0]           memory_line,
  output logic                  write_memory_en,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] next_addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic                  first_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [31:0]           line_q;
  logic                  we_q;
  logic                  wrap_q;

  logic cmd_ready;
  logic data_ready;
  logic cmd_hs;
  logic data_hs;

  // A data handshake coinciding with abort is dropped entirely.
  assign cmd_hs  = cmd_ready & host.cmd_valid;
  assign data_hs = data_ready & host.data_valid & ~host.abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    data_ready = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (host.cmd_valid) begin
          state_d = (host.cmd_count == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        data_ready = 1'b1;
        if (host.abort) begin
          state_d = IDLE;
        end else if (host.data_valid &&
                     remaining_q == (ADDR_WIDTH+1)'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr_q <= '0;
      remaining_q <= '0;
      first_q     <= 1'b0;
      wr_addr_q   <= '0;
      line_q      <= '0;
      we_q        <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      we_q <= data_hs;
      if (cmd_hs) begin
        next_addr_q <= host.cmd_base_addr;
        remaining_q <= host.cmd_count;
        first_q     <= 1'b1;
        wrap_q      <= 1'b0;
      end
      if (data_hs) begin
        wr_addr_q   <= next_addr_q;
        line_q      <= host.data;
        next_addr_q <= next_addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
        first_q     <= 1'b0;
        // Landing on address 0 after at least one earlier word means the
        // burst rolled over from DEPTH-1; a burst that starts at 0 does not.
        if (!first_q && next_addr_q == '0) begin
          wrap_q <= 1'b1;
        end
      end
    end
  end

  assign host.cmd_ready  = cmd_ready;
  assign host.data_ready = data_ready;

  assign memory_write_addr = wr_addr_q;
  assign memory_line       = line_q;
  assign write_memory_en   = we_q;
  assign busy              = (state_q != IDLE);
  assign done              = (state_q == DONE);
  assign wrap              = wrap_q;
  assign state_dbg         = state_q;

endmodule
